cpu_msg_broadcaster: RTL and testbench

- Transmit end of the inter-CPU index protocol.
- When the local CPU starts or finishes a job, the block wins the shared inter-CPU bus and broadcasts a CPU_R_START or CPU_R_END message together with the local CPU index.
- Every other CPU's index manager receives these broadcasts and renumbers its own index.
- Sits beside the local index manager, between the core's start/finish events and the shared message/index lines.

---
 rtl/cpu_msg_broadcaster.sv | 124 ++++++++++++
 tb/tb_cpu_msg_broadcaster.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_msg_broadcaster.sv
// rtl/cpu_msg_broadcaster.sv - broadcasts CPU_R_START/CPU_R_END with the local index on the inter-CPU bus
module cpu_msg_broadcaster #(
    parameter int DATA_W    = 32,
    parameter int MSG_W     = 4,
    parameter int MSG_NONE  = 0,
    parameter int MSG_START = 1,
    parameter int MSG_END   = 2,
    parameter int HOLD      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_index_in,
    input  logic              start_req,
    input  logic              finish_req,
    input  logic              bus_busy_in,
    input  logic              bus_grant,
    output logic              bus_req,
    output logic              bus_busy_out,
    output logic              msg_oe,
    output logic [MSG_W-1:0]  msg_out,
    output logic [DATA_W-1:0] index_out,
    output logic              start_done,
    output logic              finish_done
);

    typedef enum logic [1:0] {IDLE, REQ, DRIVE, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              pend_s_q, pend_s_d;
    logic              pend_f_q, pend_f_d;
    logic              sel_end_q, sel_end_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              bus_req_d, bus_busy_d, msg_oe_d, start_done_d, finish_done_d;
    logic [MSG_W-1:0]  msg_out_d;
    logic [DATA_W-1:0] index_d;

    // Next state, pending bits and the output values they imply for the next cycle
    always_comb begin
        state_d   = state_q;
        pend_s_d  = pend_s_q;
        pend_f_d  = pend_f_q;
        sel_end_d = sel_end_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (pend_s_q || pend_f_q) state_d = REQ;
            end
            REQ: begin
                if (bus_grant && !bus_busy_in) begin
                    state_d   = DRIVE;
                    sel_end_d = !pend_s_q;          // START wins when both are pending
                    cnt_d     = 4'(HOLD - 1);
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) state_d = RELEASE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RELEASE: begin
                if (sel_end_q) pend_f_d = 1'b0;
                else           pend_s_d = 1'b0;
                state_d = (sel_end_q ? pend_s_q : pend_f_q) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // New requests override the clear so a request in RELEASE is never lost
        if (start_req)  pend_s_d = 1'b1;
        if (finish_req) pend_f_d = 1'b1;

        bus_req_d     = (state_d == REQ) || (state_d == DRIVE);
        bus_busy_d    = (state_d == DRIVE);
        msg_oe_d      = (state_d == DRIVE) || (state_d == RELEASE);
        start_done_d  = (state_d == RELEASE) && !sel_end_d;
        finish_done_d = (state_d == RELEASE) && sel_end_d;

        if (state_d == DRIVE)
            msg_out_d = sel_end_d ? MSG_W'(MSG_END) : MSG_W'(MSG_START);
        else
            msg_out_d = MSG_W'(MSG_NONE);

        // The MSB of the broadcast index tells receivers START (0) from END (1)
        if (state_q == REQ && state_d == DRIVE)
            index_d = {sel_end_d, cpu_index_in[DATA_W-2:0]};
        else if (state_d == DRIVE || state_d == RELEASE)
            index_d = index_out;
        else
            index_d = '0;
    end

    // State, pending bits, hold counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_s_q     <= 1'b0;
            pend_f_q     <= 1'b0;
            sel_end_q    <= 1'b0;
            cnt_q        <= 4'd0;
            bus_req      <= 1'b0;
            bus_busy_out <= 1'b0;
            msg_oe       <= 1'b0;
            msg_out      <= MSG_W'(MSG_NONE);
            index_out    <= '0;
            start_done   <= 1'b0;
            finish_done  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_s_q     <= pend_s_d;
            pend_f_q     <= pend_f_d;
            sel_end_q    <= sel_end_d;
            cnt_q        <= cnt_d;
            bus_req      <= bus_req_d;
            bus_busy_out <= bus_busy_d;
            msg_oe       <= msg_oe_d;
            msg_out      <= msg_out_d;
            index_out    <= index_d;
            start_done   <= start_done_d;
            finish_done  <= finish_done_d;
        end
    end

endmodule

// File: tb/tb_cpu_msg_broadcaster.sv
// tb/tb_cpu_msg_broadcaster.sv - randomized self-checking bench for cpu_msg_broadcaster
module tb_cpu_msg_broadcaster;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_index_in;
    logic        start_req, finish_req, bus_busy_in, bus_grant;
    logic        bus_req, bus_busy_out, msg_oe, start_done, finish_done;
    logic [3:0]  msg_out;
    logic [31:0] index_out;

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;
    int n_sd, n_fd, sd_at, fd_at;

    // reference model: broadcast position 0 idle, 1 requesting,
    // 2..HOLD+1 holding the message, HOLD+2 release cycle
    int          m_pos;
    bit          m_ps, m_pf, m_end;
    logic [31:0] m_idx;

    cpu_msg_broadcaster #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .cpu_index_in(cpu_index_in),
        .start_req(start_req), .finish_req(finish_req),
        .bus_busy_in(bus_busy_in), .bus_grant(bus_grant),
        .bus_req(bus_req), .bus_busy_out(bus_busy_out), .msg_oe(msg_oe),
        .msg_out(msg_out), .index_out(index_out),
        .start_done(start_done), .finish_done(finish_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_ps = 0; m_pf = 0; m_end = 0; m_idx = '0;
    endtask

    task automatic model_step();
        bit ops, opf;
        ops = m_ps; opf = m_pf;
        if (m_pos == 0) begin
            if (ops || opf) m_pos = 1;
        end else if (m_pos == 1) begin
            if (bus_grant && !bus_busy_in) begin
                m_end = !ops;
                m_idx = {m_end, cpu_index_in[30:0]};
                m_pos = 2;
            end
        end else if (m_pos <= HOLD + 1) begin
            m_pos++;
        end else begin
            if (m_end) m_pf = 0; else m_ps = 0;
            m_pos = (m_end ? ops : opf) ? 1 : 0;
        end
        if (start_req)  m_ps = 1;
        if (finish_req) m_pf = 1;
    endtask

    task automatic compare_model();
        bit drv, rel;
        logic [8:0] exp_ctrl;
        drv = (m_pos >= 2) && (m_pos <= HOLD + 1);
        rel = (m_pos == HOLD + 2);
        exp_ctrl = {(m_pos >= 1) && (m_pos <= HOLD + 1), drv, drv || rel,
                    drv ? (m_end ? 4'd2 : 4'd1) : 4'd0, rel && !m_end, rel && m_end};
        check("ctrl", 64'({bus_req, bus_busy_out, msg_oe, msg_out, start_done, finish_done}), 64'(exp_ctrl));
        check("index", 64'(index_out), 64'((drv || rel) ? m_idx : 32'h0));
    endtask

    // one clock: drive inputs, advance model, sample 1 time unit after the edge
    task automatic cyc(input bit s, input bit f, input bit g, input bit b, input logic [31:0] idx);
        start_req = s; finish_req = f; bus_grant = g; bus_busy_in = b; cpu_index_in = idx;
        model_step();
        @(posedge clk);
        #1;
        cyc_no++;
        compare_model();
        if (start_done)  begin n_sd++; sd_at = cyc_no; end
        if (finish_done) begin n_fd++; fd_at = cyc_no; end
    endtask

    task automatic idle(input int n, input logic [31:0] idx);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, idx);
    endtask

    task automatic clear_counts();
        n_sd = 0; n_fd = 0; sd_at = 0; fd_at = 0;
    endtask

    initial begin
        rst = 1'b1;
        start_req = 0; finish_req = 0; bus_grant = 0; bus_busy_in = 0; cpu_index_in = '0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({bus_req, bus_busy_out, msg_oe, msg_out, start_done, finish_done}), 64'd0);
        check("reset_index", 64'(index_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // single START broadcast
        clear_counts();
        cyc(1, 0, 1, 0, 32'h3);
        idle(7, 32'h3);
        check("t1_start_done", 64'(n_sd), 64'd1);
        check("t1_bus_req_off", 64'(bus_req), 64'd0);

        // single END broadcast
        clear_counts();
        cyc(0, 1, 1, 0, 32'h5);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 1, 0, 32'h5);
            if (msg_out == 4'd2) check("t2_end_index", 64'(index_out), 64'h80000005);
        end
        check("t2_finish_done", 64'(n_fd), 64'd1);

        // bus busy holds off the broadcast
        clear_counts();
        cyc(1, 0, 1, 1, 32'h7);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 32'h7);
        check("t3_wait_oe", 64'({bus_req, msg_oe}), 64'b10);
        idle(8, 32'h7);
        check("t3_start_done", 64'(n_sd), 64'd1);

        // both requests together: START then END
        clear_counts();
        cyc(1, 1, 1, 0, 32'h9);
        idle(14, 32'h9);
        check("t4_counts", 64'({n_sd[7:0], n_fd[7:0]}), 64'h0101);
        check("t4_order", 64'(sd_at < fd_at), 64'd1);

        // repeat START during DRIVE is absorbed
        clear_counts();
        cyc(1, 0, 1, 0, 32'h11);
        for (int i = 0; i < 10; i++) cyc(m_pos == 2, 0, 1, 0, 32'h11);
        check("t5_absorbed", 64'(n_sd), 64'd1);

        // repeat START exactly in RELEASE gives a second broadcast
        clear_counts();
        cyc(1, 0, 1, 0, 32'h12);
        for (int i = 0; i < 14; i++) cyc((m_pos == HOLD + 2) && (n_sd == 1), 0, 1, 0, 32'h12);
        check("t5_rerun", 64'(n_sd), 64'd2);

        // asynchronous reset in the middle of DRIVE
        clear_counts();
        cyc(1, 1, 1, 0, 32'h21);
        for (int i = 0; i < 20 && m_pos != 2; i++) cyc(0, 0, 1, 0, 32'h21);
        check("t6_reached_drive", 64'(m_pos), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_ctrl", 64'({bus_req, bus_busy_out, msg_oe, msg_out, start_done, finish_done}), 64'd0);
        check("t6_async_index", 64'(index_out), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(8, 32'h21);
        check("t6_no_done", 64'({n_sd[7:0], n_fd[7:0]}), 64'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                ($urandom % 4) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
